// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcode constants and sequencer state encoding
//   DATA_W  operand / result width
//   SEL_W   opcode width
//   OP_*    opcode values understood by the external ALU
//   state_t sequencer FSM states
package alu_pkg;

    localparam int DATA_W = 9;
    localparam int SEL_W  = 4;

    localparam logic [SEL_W-1:0] OP_ADD = 4'd0;
    localparam logic [SEL_W-1:0] OP_SUB = 4'd1;
    localparam logic [SEL_W-1:0] OP_SHL = 4'd2;
    localparam logic [SEL_W-1:0] OP_SHR = 4'd3;
    localparam logic [SEL_W-1:0] OP_AND = 4'd4;
    localparam logic [SEL_W-1:0] OP_OR  = 4'd5;
    localparam logic [SEL_W-1:0] OP_XOR = 4'd6;
    localparam logic [SEL_W-1:0] OP_NOT = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_res_classify.sv
// alu_res_classify: combinational flag/magnitude derivation for one ALU result
//   op   in   opcode that produced data
//   data in   raw ALU result
//   err  out  carry-out of add / shl (top bit set)
//   neg  out  subtract result is negative (top bit set)
//   mag  out  two's-complement magnitude when neg, else data
module alu_res_classify
    import alu_pkg::*;
(
    input  logic [SEL_W-1:0]  op,
    input  logic [DATA_W-1:0] data,
    output logic              err,
    output logic              neg,
    output logic [DATA_W-1:0] mag
);

    assign err = (op == OP_ADD || op == OP_SHL) && data[DATA_W-1];
    assign neg = (op == OP_SUB) && data[DATA_W-1];
    assign mag = neg ? -data : data;

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: steps an external ALU through opcodes 0..LAST_OP and captures each result
//   Optional build macro ALU_OP_SEQUENCER_STOP_ON_ERR_EN: end the sequence at the first result with res_err.
//   clk, rst (sync, active-high)
//   start             request one sequence (honoured only in IDLE)
//   num1, num2        operands latched on an accepted start
//   alu_out           combinational ALU result for A, B, select
//   A, B, select      operands and opcode driven to the ALU
//   busy              high outside IDLE
//   res_valid         one-cycle pulse while res_* hold a fresh capture
//   res_op/data/mag   captured opcode, raw result, magnitude
//   res_err, res_neg  overflow / negative flags of the capture
//   done              one-cycle pulse at sequence end
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned      HOLD_CYCLES = 1,
    parameter logic [SEL_W-1:0] LAST_OP     = 4'd7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] num1,
    input  logic [DATA_W-1:0] num2,
    input  logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [SEL_W-1:0]  select,
    output logic              busy,
    output logic              res_valid,
    output logic [SEL_W-1:0]  res_op,
    output logic [DATA_W-1:0] res_data,
    output logic [DATA_W-1:0] res_mag,
    output logic              res_err,
    output logic              res_neg,
    output logic              done
);

    localparam logic [3:0] HOLD = 4'(HOLD_CYCLES);

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic              wait_last;
    logic              stop_err;
    logic              busy_d;
    logic              res_valid_d;
    logic              done_d;
    logic              cls_err;
    logic              cls_neg;
    logic [DATA_W-1:0] cls_mag;

    alu_res_classify u_cls (
        .op   (select),
        .data (alu_out),
        .err  (cls_err),
        .neg  (cls_neg),
        .mag  (cls_mag)
    );

    // Counter is loaded in ISSUE, so the WAIT cycle that sees 1 is the last one.
    assign wait_last = cnt == 4'd1;

`ifdef ALU_OP_SEQUENCER_STOP_ON_ERR_EN
    assign stop_err = res_err;
`else
    assign stop_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    state_next = start ? S_ISSUE : S_IDLE;
            S_ISSUE:   state_next = S_WAIT;
            S_WAIT:    state_next = wait_last ? S_CAPTURE : S_WAIT;
            S_CAPTURE: state_next = (select == LAST_OP || stop_err) ? S_DONE : S_ISSUE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the upcoming state so they align with it.
    always_comb begin
        busy_d      = state_next != S_IDLE;
        res_valid_d = state_next == S_CAPTURE;
        done_d      = state_next == S_DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            A         <= '0;
            B         <= '0;
            select    <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_op    <= '0;
            res_data  <= '0;
            res_mag   <= '0;
            res_err   <= 1'b0;
            res_neg   <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
        end else begin
            busy      <= busy_d;
            res_valid <= res_valid_d;
            done      <= done_d;
            cnt       <= state == S_ISSUE ? HOLD : state == S_WAIT ? cnt - 4'd1 : cnt;
            if (state == S_IDLE && start) begin
                A      <= num1;
                B      <= num2;
                select <= '0;
            end
            if (state == S_CAPTURE && state_next == S_ISSUE)
                select <= select + 4'd1;
            if (state == S_WAIT && wait_last) begin
                res_op   <= select;
                res_data <= alu_out;
                res_mag  <= cls_mag;
                res_err  <= cls_err;
                res_neg  <= cls_neg;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random sequences on HOLD_CYCLES=1 and =4 instances against a reference model
module tb_alu_op_sequencer;
    import alu_pkg::*;

`ifdef ALU_OP_SEQUENCER_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif
    localparam int LAST = 7;

    typedef struct {
        int op;
        int data;
        int err;
        int neg;
        int mag;
        int cyc;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [8:0] num1 = '0;
    logic [8:0] num2 = '0;
    logic [8:0] a [2];
    logic [8:0] b [2];
    logic [8:0] aout [2];
    logic [8:0] rd [2];
    logic [8:0] rm [2];
    logic [3:0] sel [2];
    logic [3:0] rop [2];
    logic       busy [2];
    logic       rv [2];
    logic       re [2];
    logic       rn [2];
    logic       dn [2];

    int   vectors = 0;
    int   fails = 0;
    int   cyc = 0;
    int   cur_n1 = 0;
    int   cur_n2 = 0;
    rec_t q0 [$];
    rec_t q1 [$];
    int   d0 [$];
    int   d1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU behaviour seen by both instances
    function automatic logic [8:0] alu(input logic [3:0] op, input logic [8:0] x, input logic [8:0] y);
        case (op)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x << 1;
            4'd3:    return x >> 1;
            4'd4:    return x & y;
            4'd5:    return x | y;
            4'd6:    return x ^ y;
            4'd7:    return ~x;
            default: return '0;
        endcase
    endfunction

    assign aout[0] = alu(sel[0], a[0], b[0]);
    assign aout[1] = alu(sel[1], a[1], b[1]);

    alu_op_sequencer #(.HOLD_CYCLES(1)) d_h1 (
        .clk(clk), .rst(rst), .start(start), .num1(num1), .num2(num2), .alu_out(aout[0]),
        .A(a[0]), .B(b[0]), .select(sel[0]), .busy(busy[0]), .res_valid(rv[0]), .res_op(rop[0]),
        .res_data(rd[0]), .res_mag(rm[0]), .res_err(re[0]), .res_neg(rn[0]), .done(dn[0])
    );

    alu_op_sequencer #(.HOLD_CYCLES(4)) d_h4 (
        .clk(clk), .rst(rst), .start(start), .num1(num1), .num2(num2), .alu_out(aout[1]),
        .A(a[1]), .B(b[1]), .select(sel[1]), .busy(busy[1]), .res_valid(rv[1]), .res_op(rop[1]),
        .res_data(rd[1]), .res_mag(rm[1]), .res_err(re[1]), .res_neg(rn[1]), .done(dn[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rec_t mk(input int j);
        rec_t r;
        r.op   = int'(rop[j]);
        r.data = int'(rd[j]);
        r.err  = int'(re[j]);
        r.neg  = int'(rn[j]);
        r.mag  = int'(rm[j]);
        r.cyc  = cyc;
        return r;
    endfunction

    // Observe both instances away from the clock edge
    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (busy[j]) begin
                chk(j ? "h4_A_hold" : "h1_A_hold", a[j], cur_n1);
                chk(j ? "h4_B_hold" : "h1_B_hold", b[j], cur_n2);
            end
        end
        if (rv[0]) begin
            chk("h1_select_at_capture", sel[0], q0.size());
            q0.push_back(mk(0));
        end
        if (rv[1]) begin
            chk("h4_select_at_capture", sel[1], q1.size());
            q1.push_back(mk(1));
        end
        if (dn[0]) d0.push_back(cyc);
        if (dn[1]) d1.push_back(cyc);
    end

    task automatic check_idle(input int j);
        chk("idle_A", a[j], 0);
        chk("idle_B", b[j], 0);
        chk("idle_select", sel[j], 0);
        chk("idle_busy", busy[j], 0);
        chk("idle_res_valid", rv[j], 0);
        chk("idle_res_op", rop[j], 0);
        chk("idle_res_data", rd[j], 0);
        chk("idle_res_mag", rm[j], 0);
        chk("idle_res_err", re[j], 0);
        chk("idle_res_neg", rn[j], 0);
        chk("idle_done", dn[j], 0);
    endtask

    // Compare captured results of one instance with the arithmetic model
    task automatic check_seq(input int j, input int k, input int x, input int y, input int h);
        rec_t got [$];
        int   dq [$];
        rec_t e [$];
        rec_t r;
        got = j ? q1 : q0;
        dq  = j ? d1 : d0;
        for (int i = 0; i <= LAST; i++) begin
            case (i)
                0: r.data = (x + y) % 512;
                1: r.data = (x - y + 512) % 512;
                2: r.data = (x * 2) % 512;
                3: r.data = x / 2;
                4: r.data = x & y;
                5: r.data = x | y;
                6: r.data = x ^ y;
                default: r.data = 511 - x;
            endcase
            r.op  = i;
            r.err = ((i == 0 || i == 2) && r.data >= 256) ? 1 : 0;
            r.neg = (i == 1 && r.data >= 256) ? 1 : 0;
            r.mag = r.neg ? 512 - r.data : r.data;
            r.cyc = k + i * (h + 2) + h + 1;
            e.push_back(r);
            if (STOP && r.err == 1) break;
        end
        chk("result_count", got.size(), e.size());
        for (int i = 0; i < e.size() && i < got.size(); i++) begin
            chk("res_op", got[i].op, e[i].op);
            chk("res_data", got[i].data, e[i].data);
            chk("res_err", got[i].err, e[i].err);
            chk("res_neg", got[i].neg, e[i].neg);
            chk("res_mag", got[i].mag, e[i].mag);
            chk("res_valid_cycle", got[i].cyc, e[i].cyc);
        end
        chk("done_count", dq.size(), 1);
        if (dq.size() > 0) chk("done_cycle", dq[0], k + e.size() * (h + 2));
    endtask

    // Called at a negedge with both instances idle; returns one cycle after the slow instance's done
    task automatic run(input logic [8:0] x, input logic [8:0] y, input int rp);
        int k;
        q0.delete(); q1.delete(); d0.delete(); d1.delete();
        num1 = x; num2 = y; cur_n1 = x; cur_n2 = y;
        start = 1'b1;
        k = cyc + 1;
        for (int t = 0; t < 400 && !dn[1]; t++) begin
            @(negedge clk);
            start = (rp >= 0 && cyc == k + rp);
            num1 = 9'($urandom);
            num2 = 9'($urandom);
        end
        start = 1'b0;
        @(negedge clk);
        check_seq(0, k, x, y, 1);
        check_seq(1, k, x, y, 4);
    endtask

    task automatic rst_mid_wait();
        int k;
        q0.delete(); q1.delete(); d0.delete(); d1.delete();
        num1 = 9'h070; num2 = 9'h00B; cur_n1 = 9'h070; cur_n2 = 9'h00B;
        start = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < k + 16) @(negedge clk);
        chk("pre_rst_select", sel[0], 5);
        chk("pre_rst_busy", busy[0], 1);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check_idle(0);
        check_idle(1);
        chk("pre_rst_results", q0.size(), 5);
        chk("no_done_after_rst", d0.size() + d1.size(), 0);
    endtask

    initial begin
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_idle(0);
        check_idle(1);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle(0);
        run(9'h001, 9'h0FF, -1);
        run(9'h070, 9'h00B, 9);
        run(9'h0EE, 9'h0A0, 24);
        for (int n = 0; n < 6; n++) run(9'($urandom), 9'($urandom), -1);
        rst_mid_wait();
        run(9'($urandom), 9'($urandom), -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
